// File: rtl/serial_add_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_seq_if
//  Purpose  : Request/result bundle for the bit-serial adder sequencer.
//             The master side supplies the operands and start. The slave side
//             (the sequencer) returns busy, done, sum and cout.
//  Ports    : start, a_in[WIDTH], b_in[WIDTH], cin    (master -> slave)
//             busy, done, sum[WIDTH], cout            (slave -> master)
//             ovf                                     (slave -> master,
//                                                      SERIAL_ADD_OVF_EN only)
//  Config   : SERIAL_ADD_OVF_EN adds the signed-overflow flag ovf.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_add_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a_in, b_in, cin,
`ifdef SERIAL_ADD_OVF_EN
      input  ovf,
`endif
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a_in, b_in, cin,
`ifdef SERIAL_ADD_OVF_EN
      output ovf,
`endif
      output busy, done, sum, cout
   );
endinterface
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_seq
//  Purpose  : Bit-serial adder sequencer built around a single full-adder
//             stage. Two WIDTH-bit operands are latched on an accepted start.
//             One bit pair is then processed per clock, LSB first. The carry is
//             registered between bits, and the sum is assembled in a shift
//             register. On the last bit the sequencer raises a one-cycle done
//             pulse, and sum/cout are held from then on.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - serial_add_seq_if.slave (start, a_in, b_in, cin in;
//                      busy, done, sum, cout [, ovf] out)
//  Params   : WIDTH  - operand/sum width, legal range 2..32
//  Config   : SERIAL_ADD_OVF_EN adds the registered signed-overflow flag ovf.
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   serial_add_seq_if.slave    bus
);

   localparam int              CNT_W  = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_a, w_a_nxt;
   logic [WIDTH-1:0]   r_b, w_b_nxt;
   logic [WIDTH-1:0]   r_sum, w_sum_nxt;
   logic               r_carry, w_carry_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_cout, w_cout_nxt;
`ifdef SERIAL_ADD_OVF_EN
   logic               r_ovf, w_ovf_nxt;
`endif

   // Single full-adder stage working on the current LSB pair
   logic w_fa_sum;
   logic w_fa_carry;

   assign w_fa_sum   = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_fa_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_sum   <= w_sum_nxt;
         r_carry <= w_carry_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_cout  <= w_cout_nxt;
`ifdef SERIAL_ADD_OVF_EN
         r_ovf   <= w_ovf_nxt;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_sum_nxt   = r_sum;
      w_carry_nxt = r_carry;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;          // done is a pulse and never holds by itself
      w_cout_nxt  = r_cout;
`ifdef SERIAL_ADD_OVF_EN
      w_ovf_nxt   = r_ovf;
`endif

      case (r_state)
         // DONE behaves like IDLE for acceptance, so a start held high
         // chains straight into the next add without an idle cycle.
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_a_nxt     = bus.a_in;
               w_b_nxt     = bus.b_in;
               w_carry_nxt = bus.cin;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end

         // start is not looked at here, so requests during RUN are ignored.
         S_RUN: begin
            w_a_nxt     = {1'b0, r_a[WIDTH-1:1]};
            w_b_nxt     = {1'b0, r_b[WIDTH-1:1]};
            w_sum_nxt   = {w_fa_sum, r_sum[WIDTH-1:1]};
            w_carry_nxt = w_fa_carry;
            if (r_cnt == C_LAST) begin
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_cout_nxt  = w_fa_carry;
`ifdef SERIAL_ADD_OVF_EN
               // r_carry is the carry into the MSB on this last bit.
               w_ovf_nxt   = r_carry ^ w_fa_carry;
`endif
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt   = r_cnt + C_ONE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.ovf  = r_ovf;
`endif

endmodule
`default_nettype wire
